// File: rtl/weight_bias_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | weight_bias_loader_if: header/payload stream + neuron config bus |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface weight_bias_loader_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic        weightValid;
  logic [31:0] weightValue;
  logic        biasValid;
  logic [31:0] biasValue;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  s_data, s_valid,
    output s_ready, config_layer_num, config_neuron_num,
           weightValid, weightValue, biasValid, biasValue,
           busy, done, error
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready, config_layer_num, config_neuron_num,
           weightValid, weightValue, biasValid, biasValue,
           busy, done, error
  );
endinterface
`default_nettype wire

// File: rtl/weight_bias_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | weight_bias_loader: header-driven weight/bias broadcast loader   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module weight_bias_loader #(
  parameter int maxCount   = 784,
  parameter int countWidth = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  weight_bias_loader_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    GAP     = 2'd2
  } state_t;

  localparam logic [1:0]            c_type_weight = 2'b01;
  localparam logic [1:0]            c_type_bias   = 2'b10;
  localparam logic [countWidth-1:0] c_max_cnt     = countWidth'(maxCount);
  localparam logic [countWidth-1:0] c_one         = countWidth'(1);

  state_t                r_state;
  logic [countWidth-1:0] r_count;
  logic [countWidth-1:0] r_target;
  logic                  r_is_bias;
  logic [31:0]           r_layer;
  logic [31:0]           r_neuron;
  logic                  r_weight_valid;
  logic [31:0]           r_weight_value;
  logic                  r_bias_valid;
  logic [31:0]           r_bias_value;
  logic                  r_done;
  logic                  r_error;

  logic [1:0]            w_type;
  logic [3:0]            w_layer;
  logic [9:0]            w_neuron;
  logic [countWidth-1:0] w_count;
  logic                  w_ready;
  logic                  w_beat;
  logic                  w_hdr_ok;
  logic                  w_last;

  assign w_type   = bus.s_data[31:30];
  assign w_layer  = bus.s_data[29:26];
  assign w_neuron = bus.s_data[25:16];
  assign w_count  = bus.s_data[countWidth-1:0];

  // Ready is gated by rst directly so no beat can be taken in the reset cycle.
  assign w_ready  = ~rst & (r_state != GAP);
  assign w_beat   = bus.s_valid & w_ready;
  assign w_hdr_ok = ((w_type == c_type_weight) && (w_count != '0) && (w_count <= c_max_cnt)) ||
                    ((w_type == c_type_bias) && (w_count == c_one));
  assign w_last   = ((r_count + c_one) == r_target);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_target       <= '0;
      r_is_bias      <= 1'b0;
      r_layer        <= '0;
      r_neuron       <= '0;
      r_weight_valid <= 1'b0;
      r_weight_value <= '0;
      r_bias_valid   <= 1'b0;
      r_bias_value   <= '0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_weight_valid <= 1'b0;
      r_bias_valid   <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_beat) begin
            if (w_hdr_ok) begin
              r_layer   <= {28'd0, w_layer};
              r_neuron  <= {22'd0, w_neuron};
              r_target  <= w_count;
              r_count   <= '0;
              r_is_bias <= (w_type == c_type_bias);
              r_state   <= PAYLOAD;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (w_beat) begin
            if (r_is_bias) begin
              r_bias_valid <= 1'b1;
              r_bias_value <= bus.s_data;
            end else begin
              r_weight_valid <= 1'b1;
              r_weight_value <= bus.s_data;
            end
            r_count <= r_count + c_one;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= GAP;
            end
          end
        end
        // One dead cycle keeps config stable past the final strobe.
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready           = w_ready;
  assign bus.config_layer_num  = r_layer;
  assign bus.config_neuron_num = r_neuron;
  assign bus.weightValid       = r_weight_valid;
  assign bus.weightValue       = r_weight_value;
  assign bus.biasValid         = r_bias_valid;
  assign bus.biasValue         = r_bias_value;
  assign bus.busy              = (r_state == PAYLOAD);
  assign bus.done              = r_done;
  assign bus.error             = r_error;

endmodule
`default_nettype wire

// File: tb/tb_weight_bias_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_weight_bias_loader: directed bench with per-cycle model check |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_weight_bias_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_bias_loader_if bus ();

  weight_bias_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  // Transfer-level model state: words still owed and a pending dead cycle.
  int          m_rem  = 0;
  bit          m_gap  = 1'b0;
  bit          m_bias = 1'b0;
  logic [31:0] e_layer = '0, e_neuron = '0, e_wval = '0, e_bval = '0;
  logic        e_wv = 1'b0, e_bv = 1'b0, e_done = 1'b0, e_err = 1'b0, e_busy = 1'b0;

  logic [31:0] wlog[$];
  logic [31:0] blog[$];
  int          done_cnt = 0;
  logic [31:0] prev_neuron = '0, prev_layer = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hdr(input int typ, input int layer, input int neuron, input int cnt);
    return (32'(typ) << 30) | (32'(layer) << 26) | (32'(neuron) << 16) | 32'(cnt & 16'hFFFF);
  endfunction

  always @(posedge clk) begin
    bit beat;
    int typ, cnt;
    if (rst) begin
      m_rem = 0; m_gap = 0; m_bias = 0;
      e_layer = 0; e_neuron = 0; e_wval = 0; e_bval = 0;
      e_wv = 0; e_bv = 0; e_done = 0; e_err = 0;
    end else begin
      e_wv = 0; e_bv = 0; e_done = 0;
      beat = bus.s_valid && !m_gap;
      if (m_gap) begin
        m_gap = 0;
      end else if (m_rem == 0) begin
        if (beat) begin
          typ = int'(bus.s_data >> 30);
          cnt = int'(bus.s_data & 32'hFFFF);
          if ((typ == 1 && cnt >= 1 && cnt <= 784) || (typ == 2 && cnt == 1)) begin
            e_layer  = (bus.s_data >> 26) & 32'hF;
            e_neuron = (bus.s_data >> 16) & 32'h3FF;
            m_rem    = cnt;
            m_bias   = (typ == 2);
          end else begin
            e_err = 1;
          end
        end
      end else if (beat) begin
        if (m_bias) begin e_bv = 1; e_bval = bus.s_data; end
        else        begin e_wv = 1; e_wval = bus.s_data; end
        m_rem--;
        if (m_rem == 0) begin e_done = 1; m_gap = 1; end
      end
    end
    e_busy = (m_rem > 0);
  end

  always @(negedge clk) begin
    if (checking) begin
      check("s_ready", {31'd0, bus.s_ready}, {31'd0, !rst && !m_gap});
      check("layer", bus.config_layer_num, e_layer);
      check("neuron", bus.config_neuron_num, e_neuron);
      check("weightValid", {31'd0, bus.weightValid}, {31'd0, e_wv});
      check("weightValue", bus.weightValue, e_wval);
      check("biasValid", {31'd0, bus.biasValid}, {31'd0, e_bv});
      check("biasValue", bus.biasValue, e_bval);
      check("busy", {31'd0, bus.busy}, {31'd0, e_busy});
      check("done", {31'd0, bus.done}, {31'd0, e_done});
      check("error", {31'd0, bus.error}, {31'd0, e_err});
      if ((bus.config_neuron_num !== prev_neuron) || (bus.config_layer_num !== prev_layer))
        check("strobe_on_cfg_change", {31'd0, bus.weightValid | bus.biasValid}, 32'd0);
      prev_neuron = bus.config_neuron_num;
      prev_layer  = bus.config_layer_num;
      if (bus.weightValid === 1'b1) wlog.push_back(bus.weightValue);
      if (bus.biasValid === 1'b1)   blog.push_back(bus.biasValue);
      if (bus.done === 1'b1)        done_cnt++;
    end
  end

  task automatic send(input logic [31:0] w, input int stall_pct);
    bit acc = 0;
    while ($urandom_range(99) < stall_pct) begin
      bus.s_valid = 1'b0;
      @(posedge clk); #2;
    end
    bus.s_data  = w;
    bus.s_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk); #2;
      if (acc) break;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: word %h never accepted", w);
    end
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_logs();
    wlog.delete(); blog.delete(); done_cnt = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1; bus.s_valid = 1'b0; bus.s_data = '0;
    @(posedge clk); #2;
    checking = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("reset_error", {31'd0, bus.error}, 32'd0);
    check("reset_layer", bus.config_layer_num, 32'd0);

    // Basic three-word weight transfer
    clear_logs();
    send(32'h4C05_0003, 0);
    send(32'h11, 0); send(32'h22, 0); send(32'h33, 0);
    idle(3);
    check("t1_count", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      check("t1_w0", wlog[0], 32'h11);
      check("t1_w1", wlog[1], 32'h22);
      check("t1_w2", wlog[2], 32'h33);
    end
    check("t1_done", 32'(done_cnt), 32'd1);
    check("t1_layer", bus.config_layer_num, 32'd3);
    check("t1_neuron", bus.config_neuron_num, 32'd5);

    // Single bias word
    clear_logs();
    send(32'h8000_0001, 0);
    send(32'hFFFF_8000, 0);
    idle(3);
    check("t2_bias_count", 32'(blog.size()), 32'd1);
    if (blog.size() == 1) check("t2_bias_val", blog[0], 32'hFFFF_8000);
    check("t2_weight_count", 32'(wlog.size()), 32'd0);
    check("t2_done", 32'(done_cnt), 32'd1);

    // Full-size transfer with random stalls
    clear_logs();
    send(hdr(1, 7, 9, 784), 0);
    for (int i = 1; i <= 784; i++) send(32'(i), 30);
    idle(3);
    check("t3_count", 32'(wlog.size()), 32'd784);
    bad = 0;
    foreach (wlog[i]) if (wlog[i] !== 32'(i + 1)) bad++;
    check("t3_order", 32'(bad), 32'd0);
    check("t3_layer", bus.config_layer_num, 32'd7);
    check("t3_neuron", bus.config_neuron_num, 32'd9);

    // Illegal headers
    clear_logs();
    send(32'h0000_0004, 0);
    idle(1);
    check("t4_error_sticky", {31'd0, bus.error}, 32'd1);
    send(32'hC000_0001, 0);
    send(hdr(1, 1, 1, 0), 0);
    send(hdr(1, 1, 1, 785), 0);
    send(hdr(2, 1, 1, 2), 0);
    idle(2);
    check("t4_no_strobes", 32'(wlog.size() + blog.size()), 32'd0);
    check("t4_layer_kept", bus.config_layer_num, 32'd7);
    check("t4_neuron_kept", bus.config_neuron_num, 32'd9);
    send(hdr(1, 2, 1, 1), 0);
    send(32'hABCD, 0);
    idle(3);
    check("t4_legal_count", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) check("t4_legal_val", wlog[0], 32'hABCD);
    check("t4_legal_neuron", bus.config_neuron_num, 32'd1);

    // Reset in the middle of a transfer
    clear_logs();
    send(hdr(1, 4, 4, 5), 0);
    send(32'h1, 0); send(32'h2, 0);
    rst = 1'b1; bus.s_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    check("t5_error_cleared", {31'd0, bus.error}, 32'd0);
    check("t5_layer_zero", bus.config_layer_num, 32'd0);
    send(32'h3, 0); send(32'h4, 0); send(32'h5, 0);
    idle(3);
    check("t5_strobes", 32'(wlog.size()), 32'd2);
    check("t5_done", 32'(done_cnt), 32'd0);
    check("t5_error_as_hdr", {31'd0, bus.error}, 32'd1);

    // Back-to-back headers with s_valid held high
    clear_logs();
    send(hdr(1, 1, 0, 2), 0);
    send(32'hA, 0); send(32'hB, 0);
    send(hdr(1, 1, 1, 1), 0);
    send(32'hC, 0);
    idle(3);
    check("t6_count", 32'(wlog.size()), 32'd3);
    check("t6_neuron", bus.config_neuron_num, 32'd1);
    check("t6_done", 32'(done_cnt), 32'd2);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/weight_bias_loader.md
Name: weight_bias_loader

Overview:
- Initiator side of the neuron weight/bias configuration bus.
- Accepts a 32-bit word stream of header + payload words from the host DMA/AXI-lite bridge.
- Drives config_layer_num / config_neuron_num / weightValid / weightValue / biasValid / biasValue, which every neuron in every layer snoops.
- One header selects one (layer, neuron) target. The following payload words are broadcast one per cycle, with the target neuron self-selecting on layer/neuron match.

Parameters:
- maxCount, 784, largest legal payload count per header (weights per neuron).
- countWidth, 16, width of header count field; fixed by header format.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_data  in  32  stream word (header or payload)
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts s_data this cycle (beat = s_valid & s_ready)
- config_layer_num  out  32  target layer, zero-extended
- config_neuron_num  out  32  target neuron, zero-extended
- weightValid  out  1  one-cycle strobe per weight word
- weightValue  out  32  weight word
- biasValid  out  1  one-cycle strobe for bias word
- biasValue  out  32  bias word
- busy  out  1  high while in PAYLOAD state
- done  out  1  one-cycle pulse on final payload strobe
- error  out  1  sticky protocol error flag

Behaviour:
- Header word fields:
  - [31:30] type: 01 = weight, 10 = bias, 00/11 = illegal.
  - [29:26] layer.
  - [25:16] neuron.
  - [15:0] count.
- Reset: all outputs 0, s_ready 0 in the cycle reset is asserted, state IDLE, internal counter 0, error cleared. Reset mid-payload abandons the transfer; no further strobes.
- s_ready = 1 in IDLE and PAYLOAD states; 0 in GAP state and during reset.
- IDLE:
  - On a header beat, register layer/neuron into config_layer_num/config_neuron_num (visible the next cycle); latch type and count.
  - Next state is PAYLOAD, with these exceptions:
    - Illegal type: error <= 1, header dropped, stay IDLE, config outputs unchanged.
    - Weight count = 0 or count > maxCount: error <= 1, stay IDLE.
    - Bias with count != 1: error <= 1, stay IDLE.
- PAYLOAD:
  - Each beat produces weightValid (or biasValid) = 1 exactly one cycle after the beat, with weightValue/biasValue = s_data of that beat.
  - Value outputs hold their last value when the strobe is low.
  - Counter increments per beat. On the beat that reaches count: state -> GAP, and done pulses in the same cycle as the final strobe.
  - s_valid low stalls without strobes; there is no timeout.
- GAP: one cycle, s_ready = 0, then IDLE. This guarantees that config_layer_num/neuron_num change at least one cycle after the last strobe.
- config_layer_num/config_neuron_num stay stable from the first strobe through the last strobe of a transfer, and hold until the next legal header.
- weightValid and biasValid are never high together. The strobe is never high in the cycle config outputs change.
- Neurons reset their weight write address on rst only. Software must send each neuron's weights in a single header of exactly numWeight words after reset; the loader does not track per-neuron history.
- error: sticky until rst. Legal transfers continue to work while error = 1.
- busy = 1 in PAYLOAD only.

Test Plan:
- Header 0x4C05_0003 (weight, layer 3, neuron 5, count 3), then payloads 0x11, 0x22, 0x33 on consecutive cycles:
  - config_layer_num = 3 and config_neuron_num = 5 from cycle after header.
  - weightValid high 3 consecutive cycles with values 0x11, 0x22, 0x33.
  - done coincides with 0x33; s_ready low 1 cycle after.
- Bias header 0x8000_0001 (layer 0, neuron 0), payload 0xFFFF_8000 -> single biasValid with biasValue 0xFFFF_8000; weightValid stays 0; done pulses.
- Weight header count 784, s_valid randomly deasserted:
  - Exactly 784 weightValid strobes, in order, no strobe on stalled cycles.
  - busy high throughout.
  - config outputs constant throughout.
- Illegal headers 0x0000_0004, 0xC000_0001, weight count 0, weight count 785, and bias count 2:
  - error = 1 after the first; no strobes.
  - State stays IDLE (next legal header accepted).
  - config outputs unchanged.
- rst asserted after 2 of 5 payload beats:
  - All outputs 0 the next cycle; no further strobes.
  - The remaining 3 words presented after reset are treated as headers (type decoded from [31:30]).
- Back-to-back headers for neuron 0 then neuron 1, with s_valid held high:
  - One GAP cycle between the last strobe of neuron 0 and the header accept for neuron 1.
  - No strobe occurs while config_neuron_num changes.
